// File: rtl/sysarr_seq.sv
// sysarr_seq -- control sequencer for a DIM x DIM systolic matrix multiplier.
//
// Purpose: loads DIM rows of A and DIM rows of B from a valid/ready source.
// It then runs the skew FIFOs and MAC array for 3*DIM-2 cycles, streams the
// DIM result rows to a sink, and emits a one-cycle done pulse.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   start      job request, honoured only in IDLE
//   abort      cancel current job, honoured in any non-IDLE state
//   ab_valid   source presents an operand row
//   ab_ready   sequencer accepts an operand row (LOAD_A / LOAD_B)
//   a_wr_en    A memory write strobe, a_row its target row
//   b_wr_en    B memory write strobe, b_row its target row
//   shift_en   skew FIFO / MAC array enable (COMPUTE)
//   mac_clr    accumulator clear, same cycle as an accepted start
//   c_valid    result row c_row presented (OUTPUT)
//   out_ready  sink consumes the presented result row
//   busy       high outside IDLE
//   done       one-cycle completion pulse
module sysarr_seq #(
  parameter int DIM     = 8,
  parameter int BITS_AB = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   ab_valid,
  output logic                   ab_ready,
  output logic                   a_wr_en,
  output logic [$clog2(DIM)-1:0] a_row,
  output logic                   b_wr_en,
  output logic [$clog2(DIM)-1:0] b_row,
  output logic                   shift_en,
  output logic                   mac_clr,
  output logic                   c_valid,
  output logic [$clog2(DIM)-1:0] c_row,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int RW = $clog2(DIM);
  localparam int CW = $clog2(3 * DIM);
  localparam logic [RW-1:0] RLAST = RW'(DIM - 1);
  localparam logic [CW-1:0] CLAST = CW'(3 * DIM - 3);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_COMPUTE = 3'd3,
    S_OUTPUT  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [CW-1:0] ccnt_q, ccnt_d;

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rcnt_q  <= '0;
      ccnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      ccnt_q  <= ccnt_d;
    end
  end

  // Next-state, counter update and output decode.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    ccnt_d   = ccnt_q;
    ab_ready = 1'b0;
    a_wr_en  = 1'b0;
    a_row    = '0;
    b_wr_en  = 1'b0;
    b_row    = '0;
    shift_en = 1'b0;
    mac_clr  = 1'b0;
    c_valid  = 1'b0;
    c_row    = '0;
    done     = 1'b0;
    busy     = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        // A start coinciding with reset is not accepted, so no clear either.
        if (start && !rst) begin
          mac_clr = 1'b1;
          state_d = S_LOAD_A;
          rcnt_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_A: begin
        ab_ready = 1'b1;
        a_wr_en  = ab_valid;
        a_row    = rcnt_q;
        if (ab_valid) begin
          if (rcnt_q == RLAST) begin
            state_d = S_LOAD_B;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end else begin
          rcnt_d = rcnt_q;
        end
      end
      S_LOAD_B: begin
        ab_ready = 1'b1;
        b_wr_en  = ab_valid;
        b_row    = rcnt_q;
        if (ab_valid) begin
          if (rcnt_q == RLAST) begin
            state_d = S_COMPUTE;
            rcnt_d  = '0;
            ccnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end else begin
          rcnt_d = rcnt_q;
        end
      end
      S_COMPUTE: begin
        // 3*DIM-2 cycles: DIM-1 skew fill, DIM products, DIM-1 skew drain.
        shift_en = 1'b1;
        if (ccnt_q == CLAST) begin
          state_d = S_OUTPUT;
          rcnt_d  = '0;
          ccnt_d  = '0;
        end else begin
          ccnt_d = ccnt_q + CW'(1);
        end
      end
      S_OUTPUT: begin
        c_valid = 1'b1;
        c_row   = rcnt_q;
        if (out_ready) begin
          if (rcnt_q == RLAST) begin
            state_d = S_DONE;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end else begin
          rcnt_d = rcnt_q;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        rcnt_d  = '0;
        ccnt_d  = '0;
      end
    endcase

    // Abort outranks every transition above; outputs keep the current state.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      rcnt_d  = '0;
      ccnt_d  = '0;
    end else begin
      state_d = state_d;
    end
  end

endmodule

// File: doc/sysarr_seq.md
SYSARR_SEQ -- requirements
Module: sysarr_seq

Interface
REQ-001 Parameter DIM, default 8, systolic array dimension (rows of A, rows of B, rows of C); DIM >= 2.
REQ-002 Parameter BITS_AB, default 8, operand width; carried for instantiation consistency only, no datapath inside this block.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request one A*B job; honoured only in IDLE.
REQ-006 abort  input  1  cancel the current job; honoured in any non-IDLE state.
REQ-007 ab_valid  input  1  source presents one operand row this cycle.
REQ-008 ab_ready  output  1  sequencer accepts an operand row this cycle.
REQ-009 a_wr_en  output  1  write strobe to the A operand memory.
REQ-010 a_row  output  $clog2(DIM)  target row for the A write.
REQ-011 b_wr_en  output  1  write strobe to the B operand memory.
REQ-012 b_row  output  $clog2(DIM)  target row for the B write.
REQ-013 shift_en  output  1  enable for the A/B skew FIFOs and the MAC array.
REQ-014 mac_clr  output  1  clear the accumulators.
REQ-015 c_valid  output  1  result row c_row is presented.
REQ-016 c_row  output  $clog2(DIM)  result row index.
REQ-017 out_ready  input  1  sink consumes the presented result row.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle completion pulse.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD_A, LOAD_B, COMPUTE, OUTPUT, DONE, held in registers. A row counter (rcnt, $clog2(DIM) bits) and a compute counter (ccnt, $clog2(3*DIM) bits) SHALL also be registered.
REQ-021 In IDLE, start=1 SHALL assert mac_clr in that same cycle (combinational) and move to LOAD_A with rcnt=0. start in any other state SHALL be ignored.
REQ-022 ab_ready SHALL be 1 only in LOAD_A and LOAD_B.
REQ-023 In LOAD_A, a_wr_en SHALL equal ab_valid and a_row SHALL equal rcnt.
  - Each cycle with ab_valid=1 increments rcnt.
  - The write with rcnt=DIM-1 moves to LOAD_B with rcnt=0.
  - ab_valid=0 stalls, with no state change.
REQ-024 LOAD_B SHALL behave identically using b_wr_en/b_row. Its final write moves to COMPUTE with ccnt=0.
REQ-025 a_wr_en and b_wr_en SHALL never be high together. Outside their load state they SHALL be 0, and a_row/b_row SHALL be 0.
REQ-026 In COMPUTE, shift_en SHALL be 1 for exactly 3*DIM-2 consecutive cycles (ccnt 0..3*DIM-3). On ccnt=3*DIM-3 the FSM moves to OUTPUT with rcnt=0. shift_en SHALL be 0 in every other state.
REQ-027 In OUTPUT, c_valid SHALL be 1 and c_row SHALL equal rcnt.
  - out_ready=1 increments rcnt.
  - out_ready=1 with rcnt=DIM-1 moves to DONE.
  - out_ready=0 holds c_row stable.
REQ-028 DONE SHALL last exactly one cycle with done=1, then return to IDLE. A start arriving during DONE is ignored.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE on the next edge and clear the counters. No done pulse is produced.
  - Outputs in the abort cycle follow the current state.
  - abort has priority over every other transition.
REQ-030 Counters SHALL never exceed their terminal values (no wrap-around inside a state).
REQ-031 With ab_valid and out_ready held at 1, start accepted in cycle t SHALL produce done in cycle t+6*DIM-1 (t+47 for DIM=8).

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE with rcnt=0 and ccnt=0, overriding start and abort, including mid-job.
REQ-033 While in IDLE after reset, all outputs SHALL be 0, except mac_clr, which follows start.

Verification
REQ-034 Reset, then start pulse at cycle t with ab_valid=out_ready=1, DIM=8:
  - mac_clr at t;
  - a_wr_en t+1..t+8 with a_row 0..7;
  - b_wr_en t+9..t+16;
  - shift_en t+17..t+38;
  - c_valid t+39..t+46;
  - done at t+47, busy low at t+48.
REQ-035 ab_valid toggled 1,0 each cycle during loading: exactly 8 A writes then 8 B writes; rows contiguous 0..7; no strobe in ab_valid=0 cycles.
REQ-036 out_ready low for 3 cycles at c_row=4: c_row stays 4, c_valid stays 1, and done is delayed by 3 cycles.
REQ-037 abort at the 5th COMPUTE cycle: IDLE next cycle, shift_en drops, and no done. A new start then completes normally.
REQ-038 rst asserted during LOAD_B with start held high: IDLE and all outputs 0 after the edge. After rst drops, the held start begins a new job and a_row restarts at 0.
REQ-039 start pulses during LOAD_A, OUTPUT and DONE: ignored, and exactly one done per accepted start.
